sram_1w1r_frontend: RTL and testbench
=====================================

Name: sram_1w1r_frontend

Overview:
Client-side front end for a 1W1R OpenRAM macro wrapper, such as the 128x44 table or 128x124 meta arrays with 4-lane write masks.
- Zero-fills the whole array after reset.
- Buffers every client write in a one-entry pending register P, so a write never hits the macro in the same cycle as a read to the same address (the macro's result is undefined in that case).
- Merges uncommitted pending lanes into read data and holds read data stable between reads.
- Drives the macro port signals directly: active-low chip selects and per-lane write mask.

Parameters:
ADDR_W, 7, address width; DEPTH = 2**ADDR_W
DATA_W, 44, data width
MASK_W, 4, write-mask lanes; LANE_W = DATA_W/MASK_W, which must be an integer
STARVE_MAX, 4, number of consecutive stalled cycles for P before reads are blocked for one cycle

Ports:
- clock  in  1  single clock; drives the macro clk0 and clk1
- reset_n  in  1  asynchronous, active-low reset
- W0_addr  in  ADDR_W  client write address
- W0_data  in  DATA_W  client write data
- W0_mask  in  MASK_W  client write lane mask
- W0_en  in  1  client write request
- W0_ready  out  1  write accepted when W0_en & W0_ready
- R0_addr  in  ADDR_W  client read address
- R0_en  in  1  client read request
- R0_ready  out  1  read accepted when R0_en & R0_ready
- R0_valid  out  1  one-cycle pulse: R0_data is the fresh result of the last accepted read
- R0_data  out  DATA_W  read data
- init_done  out  1  high once zero-fill is complete
- mem_addr0, mem_din0, mem_wmask0, mem_csb0  out  ADDR_W, DATA_W, MASK_W, 1  macro write port
- mem_addr1, mem_csb1  out  ADDR_W, 1  macro read port
- mem_dout1  in  DATA_W  macro read data; valid in the cycle after csb1 was low

Behaviour:
Reset values (async, reset_n low):
- state = INIT, init counter = 0, P empty, starvation counter = 0.
- R0_valid = 0, R0_data hold register = 0, init_done = 0, W0_ready = 0, R0_ready = 0.
- mem_csb0 = 1, mem_csb1 = 1.

INIT state:
- Each cycle: mem_csb0 = 0, mem_addr0 = counter, mem_din0 = 0, mem_wmask0 = all ones.
- Counter increments each cycle.
- After writing address DEPTH-1: go to RUN, init_done = 1 from the next cycle, held until reset.
- Client W0_en/R0_en are ignored in INIT; W0_ready = R0_ready = 0.

RUN state, pending buffer P = {valid, addr, data, mask}:
- hit = P.valid & R0_en & R0_ready & (R0_addr == P.addr).
- commit = P.valid & !hit.
- On commit: mem_csb0 = 0, with addr/din/wmask driven from P; otherwise mem_csb0 = 1.
- W0_ready = !P.valid | commit. This is combinational, with no dependency on W0_en.
- On an accepted write: P is loaded at the edge (valid = 1).
- If commit occurs and no write is accepted: P.valid is cleared.
- Reads: R0_ready = 1 unless the starvation counter equals STARVE_MAX. An accepted read drives mem_csb1 = 0 and mem_addr1 = R0_addr.

Read semantics:
- A read returns the state as of writes accepted strictly before the read cycle. A write accepted in the same cycle is not visible to that read.
- Latency: read accepted in cycle t gives R0_valid = 1 in cycle t+1.
- R0_data in t+1 is built per lane i:
  - P lane data, if P was valid at t with P.addr equal to the read address and P.mask[i] = 1 (snapshot P at t);
  - otherwise mem_dout1 lane i.
- The merged value is also captured into the hold register.
- In cycles without R0_valid, R0_data = hold register.
- Back-to-back reads are supported: one per cycle.

Starvation counter:
- Increments on each hit cycle and clears on commit.
- When it equals STARVE_MAX: R0_ready = 0 for that cycle, so P commits and the counter clears.

Reset mid-operation:
- P is discarded (the write is lost) and R0_valid = 0.
- INIT restarts at address 0.

Test Plan:
1. Reset with DEPTH = 128 -> mem_csb0 low for 128 consecutive cycles, addr 0..127, din 0, wmask 4'hF. init_done = 1 on the next cycle. A read of addr 5 returns 44'h0 with R0_valid one cycle after acceptance.
2. Write addr 3 data 44'hABC_DEF0_1234 mask 4'hF -> mem_csb0 low the following cycle with addr 3. A read of addr 3 issued two cycles after the write returns 44'hABC_DEF0_1234.
3. Collision:
   - Stimulus: addr 9 holds 44'h111_1111_1111; P holds {9, 44'h0FF_FFFF_FFFF, 4'b0011}; a read of addr 9 is accepted.
   - That cycle: mem_csb0 = 1.
   - Next cycle: R0_data = 44'h111_113F_FFFF, computed as lanes 0-1 from P and lanes 2-3 from the macro.
   - Lane math: LANE_W = 11, so lanes 0-1 are bits [21:0] = 22'h3F_FFFF from P, and bits [43:22] = 22'h04_4444 from the macro, giving 44'h111_113F_FFFF.
4. Starvation: P valid at addr 9; reads to addr 9 every cycle -> after 4 hit cycles R0_ready = 0 in the 5th cycle. Commit to addr 9 happens that cycle, and R0_ready = 1 again in the next cycle.
5. Backpressure: P stalled by a hit, new write to addr 20 held on W0_en -> W0_ready = 0 while stalled. The write is accepted in the commit cycle and committed one cycle later; no write is lost.
6. Reset mid-op: reset_n low during RUN with P valid -> R0_valid, W0_ready and init_done drop to 0 asynchronously. After release, INIT rewrites from addr 0, and the discarded P write is never seen on mem_csb0.

Source files
------------

// File: rtl/sram_1w1r_frontend.sv
// Client front end for a 1W1R OpenRAM macro: zero-fill after reset, a one-entry
// write buffer that keeps writes off an address being read, and lane-merged reads.
module sram_1w1r_frontend #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 44,
  parameter int MASK_W     = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic [DATA_W-1:0] W0_data,
  input  logic [MASK_W-1:0] W0_mask,
  input  logic              W0_en,
  output logic              W0_ready,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic              R0_ready,
  output logic              R0_valid,
  output logic [DATA_W-1:0] R0_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] mem_addr0,
  output logic [DATA_W-1:0] mem_din0,
  output logic [MASK_W-1:0] mem_wmask0,
  output logic              mem_csb0,
  output logic [ADDR_W-1:0] mem_addr1,
  output logic              mem_csb1,
  input  logic [DATA_W-1:0] mem_dout1,
  output logic              dbg_state
);

  localparam int LANE_W = DATA_W / MASK_W;
  localparam int SC_W   = $clog2(STARVE_MAX + 1);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] init_cnt;
  logic              p_valid;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  logic [MASK_W-1:0] p_mask;
  logic [SC_W-1:0]   starve_cnt;

  logic              r0_valid_q;
  logic [MASK_W-1:0] snap_mask;
  logic [DATA_W-1:0] snap_data;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] merged;

  logic              in_run;
  logic              rd_acc;
  logic              wr_acc;
  logic              hit;
  logic              commit;
  logic [MASK_W-1:0] snap_sel;

  // Handshakes: a transfer happens in a cycle where en & ready are both high;
  // ready never looks at en, and en may be held across cycles until accepted.

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && init_cnt == {ADDR_W{1'b1}}) state_nxt = S_RUN;
  end

  always_comb begin
    in_run   = (state == S_RUN);
    R0_ready = in_run && (starve_cnt != SC_W'(STARVE_MAX));
    rd_acc   = R0_en && R0_ready;
    hit      = p_valid && rd_acc && (R0_addr == p_addr);
    commit   = p_valid && !hit;
    W0_ready = in_run && (!p_valid || commit);
    wr_acc   = W0_en && W0_ready;
    snap_sel = {MASK_W{p_valid && (p_addr == R0_addr)}} & p_mask;

    mem_addr0  = p_addr;
    mem_din0   = p_data;
    mem_wmask0 = p_mask;
    mem_csb0   = !commit;
    if (!in_run) begin
      // Zero-fill sweep; held off while reset is asserted.
      mem_addr0  = init_cnt;
      mem_din0   = '0;
      mem_wmask0 = '1;
      mem_csb0   = !reset_n;
    end
    mem_csb1  = !rd_acc;
    mem_addr1 = R0_addr;
  end

  assign init_done = (state == S_RUN);
  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               init_cnt <= '0;
    else if (state == S_INIT)   init_cnt <= init_cnt + ADDR_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_valid <= 1'b0;
      p_addr  <= '0;
      p_data  <= '0;
      p_mask  <= '0;
    end else if (wr_acc) begin
      p_valid <= 1'b1;
      p_addr  <= W0_addr;
      p_data  <= W0_data;
      p_mask  <= W0_mask;
    end else if (commit) begin
      p_valid <= 1'b0;
    end
  end

  // Counts reads that keep P off the macro; at the limit one read slot is given up.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    starve_cnt <= '0;
    else if (commit) starve_cnt <= '0;
    else if (hit)    starve_cnt <= starve_cnt + SC_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r0_valid_q <= 1'b0;
      snap_mask  <= '0;
      snap_data  <= '0;
      hold_q     <= '0;
    end else begin
      r0_valid_q <= rd_acc;
      if (rd_acc) begin
        snap_mask <= snap_sel;
        snap_data <= p_data;
      end
      if (r0_valid_q) hold_q <= merged;
    end
  end

  always_comb begin
    merged = mem_dout1;
    for (int i = 0; i < MASK_W; i++) begin
      if (snap_mask[i]) merged[i*LANE_W +: LANE_W] = snap_data[i*LANE_W +: LANE_W];
    end
  end

  assign R0_valid = r0_valid_q;
  assign R0_data  = r0_valid_q ? merged : hold_q;

endmodule

// File: tb/tb_sram_1w1r_frontend.sv
// Bench for sram_1w1r_frontend: behavioural macro, reference memory scoreboard,
// directed cycle table, random traffic and reset sequences.
module tb_sram_1w1r_frontend;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 44;
  localparam int MASK_W = 4;
  localparam int LANE_W = 11;
  localparam int DEPTH  = 128;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] W0_addr = '0;
  logic [DATA_W-1:0] W0_data = '0;
  logic [MASK_W-1:0] W0_mask = '0;
  logic              W0_en = 1'b0;
  logic              W0_ready;
  logic [ADDR_W-1:0] R0_addr = '0;
  logic              R0_en = 1'b0;
  logic              R0_ready;
  logic              R0_valid;
  logic [DATA_W-1:0] R0_data;
  logic              init_done;
  logic [ADDR_W-1:0] mem_addr0;
  logic [DATA_W-1:0] mem_din0;
  logic [MASK_W-1:0] mem_wmask0;
  logic              mem_csb0;
  logic [ADDR_W-1:0] mem_addr1;
  logic              mem_csb1;
  logic [DATA_W-1:0] mem_dout1 = '0;
  logic              dbg_state;

  int checks = 0;
  int failures = 0;

  sram_1w1r_frontend dut (
    .clock(clock), .reset_n(reset_n),
    .W0_addr(W0_addr), .W0_data(W0_data), .W0_mask(W0_mask), .W0_en(W0_en), .W0_ready(W0_ready),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_ready(R0_ready), .R0_valid(R0_valid), .R0_data(R0_data),
    .init_done(init_done),
    .mem_addr0(mem_addr0), .mem_din0(mem_din0), .mem_wmask0(mem_wmask0), .mem_csb0(mem_csb0),
    .mem_addr1(mem_addr1), .mem_csb1(mem_csb1), .mem_dout1(mem_dout1),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural 1W1R macro ----------------
  logic [DATA_W-1:0] sram [DEPTH];
  logic [DATA_W-1:0] sram_w;

  always @(posedge clock) begin
    if (!mem_csb1) mem_dout1 <= sram[mem_addr1];
    if (!mem_csb0) begin
      sram_w = sram[mem_addr0];
      for (int i = 0; i < MASK_W; i++)
        if (mem_wmask0[i]) sram_w[i*LANE_W +: LANE_W] = mem_din0[i*LANE_W +: LANE_W];
      sram[mem_addr0] <= sram_w;
    end
  end

  // ---------------- scoreboard: client-level reference memory ----------------
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_exp = '0;
  logic [DATA_W-1:0] rm_w;

  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      last_exp = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      if (!mem_csb0 && !mem_csb1) check("same_cycle_rw_addr_equal", 64'(mem_addr0 == mem_addr1), 64'd0);
      if (init_done) begin
        if (R0_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_valid: got R0_valid=1 with data %0h, required no pending read", R0_data);
          end else begin
            last_exp = exp_q.pop_front();
            check("sb_read_data", 64'(R0_data), 64'(last_exp));
          end
        end else begin
          check("sb_hold_data", 64'(R0_data), 64'(last_exp));
        end
        if (R0_en && R0_ready) exp_q.push_back(ref_mem[R0_addr]);
        if (W0_en && W0_ready) begin
          rm_w = ref_mem[W0_addr];
          for (int i = 0; i < MASK_W; i++)
            if (W0_mask[i]) rm_w[i*LANE_W +: LANE_W] = W0_data[i*LANE_W +: LANE_W];
          ref_mem[W0_addr] = rm_w;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic [MASK_W-1:0] wm, input logic re, input logic [ADDR_W-1:0] ra);
    W0_en = we; W0_addr = wa; W0_data = wd; W0_mask = wm;
    R0_en = re; R0_addr = ra;
  endtask

  // Holds reset (already asserted by the caller) then follows the zero-fill sweep.
  task automatic reset_and_init();
    int errs;
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_csb0", 64'(mem_csb0), 64'd1);
    check("reset_csb1", 64'(mem_csb1), 64'd1);
    #2 reset_n = 1'b1;
    #1;
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_csb0 !== 1'b0 || mem_addr0 !== ADDR_W'(i) || mem_din0 !== '0 ||
          mem_wmask0 !== 4'hF || init_done !== 1'b0 || W0_ready !== 1'b0 || R0_ready !== 1'b0)
        errs++;
      @(negedge clock);
      #1;
    end
    check("init_sweep_errors", 64'(errs), 64'd0);
    check("init_done_after_sweep", 64'(init_done), 64'd1);
    check("csb0_idle_after_sweep", 64'(mem_csb0), 64'd1);
    check("dbg_state_run", 64'(dbg_state), 64'd1);
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [MASK_W-1:0] wm;
    logic              re;
    logic [ADDR_W-1:0] ra;
    logic              x_wready;
    logic              x_rready;
    logic              x_csb0;
    logic [ADDR_W-1:0] x_addr0;
    logic              x_rvalid;
    logic [DATA_W-1:0] x_rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  localparam logic [DATA_W-1:0] D_ABC  = 44'hABC_DEF0_1234;
  localparam logic [DATA_W-1:0] D_111  = 44'h111_1111_1111;
  localparam logic [DATA_W-1:0] D_0FF  = 44'h0FF_FFFF_FFFF;
  localparam logic [DATA_W-1:0] D_MRG  = 44'h111_113F_FFFF;
  localparam logic [DATA_W-1:0] D_20   = 44'h020_0000_0020;

  initial begin
    logic [63:0] rnd;

    //               we    wa     wd     wm     re    ra     wrdy  rrdy  csb0  addr0  rv    rdata
    vecs[0]  = '{1'b1, 7'd3,  D_ABC, 4'hF, 1'b0, 7'd0,  1'b1, 1'b1, 1'b1, 7'd0,  1'b0, 44'h0};
    vecs[1]  = '{1'b0, 7'd0,  44'h0, 4'h0, 1'b0, 7'd0,  1'b1, 1'b1, 1'b0, 7'd3,  1'b0, 44'h0};
    vecs[2]  = '{1'b0, 7'd0,  44'h0, 4'h0, 1'b1, 7'd3,  1'b1, 1'b1, 1'b1, 7'd0,  1'b0, 44'h0};
    vecs[3]  = '{1'b0, 7'd0,  44'h0, 4'h0, 1'b0, 7'd0,  1'b1, 1'b1, 1'b1, 7'd0,  1'b1, D_ABC};
    vecs[4]  = '{1'b1, 7'd9,  D_111, 4'hF, 1'b0, 7'd0,  1'b1, 1'b1, 1'b1, 7'd0,  1'b0, D_ABC};
    vecs[5]  = '{1'b1, 7'd9,  D_0FF, 4'h3, 1'b0, 7'd0,  1'b1, 1'b1, 1'b0, 7'd9,  1'b0, D_ABC};
    vecs[6]  = '{1'b0, 7'd0,  44'h0, 4'h0, 1'b1, 7'd9,  1'b0, 1'b1, 1'b1, 7'd0,  1'b0, D_ABC};
    vecs[7]  = '{1'b1, 7'd20, D_20,  4'hF, 1'b1, 7'd9,  1'b0, 1'b1, 1'b1, 7'd0,  1'b1, D_MRG};
    vecs[8]  = '{1'b1, 7'd20, D_20,  4'hF, 1'b1, 7'd9,  1'b0, 1'b1, 1'b1, 7'd0,  1'b1, D_MRG};
    vecs[9]  = '{1'b1, 7'd20, D_20,  4'hF, 1'b1, 7'd9,  1'b0, 1'b1, 1'b1, 7'd0,  1'b1, D_MRG};
    vecs[10] = '{1'b1, 7'd20, D_20,  4'hF, 1'b1, 7'd9,  1'b1, 1'b0, 1'b0, 7'd9,  1'b1, D_MRG};
    vecs[11] = '{1'b0, 7'd0,  44'h0, 4'h0, 1'b1, 7'd9,  1'b1, 1'b1, 1'b0, 7'd20, 1'b0, D_MRG};
    vecs[12] = '{1'b0, 7'd0,  44'h0, 4'h0, 1'b1, 7'd20, 1'b1, 1'b1, 1'b1, 7'd0,  1'b1, D_MRG};
    vecs[13] = '{1'b0, 7'd0,  44'h0, 4'h0, 1'b0, 7'd0,  1'b1, 1'b1, 1'b1, 7'd0,  1'b1, D_20};
    vecs[14] = '{1'b0, 7'd0,  44'h0, 4'h0, 1'b0, 7'd0,  1'b1, 1'b1, 1'b1, 7'd0,  1'b0, D_20};

    // Power-on reset and zero-fill.
    reset_and_init();

    // First read after fill returns zeros one cycle after acceptance.
    step();
    drive(1'b0, '0, '0, '0, 1'b1, 7'd5);
    @(negedge clock);
    check("rd5_ready", 64'(R0_ready), 64'd1);
    check("rd5_csb1", 64'(mem_csb1), 64'd0);
    check("rd5_addr1", 64'(mem_addr1), 64'd5);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    @(negedge clock);
    check("rd5_valid", 64'(R0_valid), 64'd1);
    check("rd5_data", 64'(R0_data), 64'd0);

    // Write/readback, collision merge, starvation and backpressure.
    for (int i = 0; i < NV; i++) begin
      step();
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].wm, vecs[i].re, vecs[i].ra);
      @(negedge clock);
      check($sformatf("v%0d_w0_ready", i), 64'(W0_ready), 64'(vecs[i].x_wready));
      check($sformatf("v%0d_r0_ready", i), 64'(R0_ready), 64'(vecs[i].x_rready));
      check($sformatf("v%0d_csb0", i), 64'(mem_csb0), 64'(vecs[i].x_csb0));
      if (!vecs[i].x_csb0) check($sformatf("v%0d_addr0", i), 64'(mem_addr0), 64'(vecs[i].x_addr0));
      check($sformatf("v%0d_r0_valid", i), 64'(R0_valid), 64'(vecs[i].x_rvalid));
      check($sformatf("v%0d_r0_data", i), 64'(R0_data), 64'(vecs[i].x_rdata));
    end

    // Random traffic on a narrow address window to provoke hits and starvation.
    for (int n = 0; n < 1500; n++) begin
      step();
      rnd = {$urandom(), $urandom()};
      drive(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), rnd[DATA_W-1:0],
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), 7'($urandom_range(0, 7)));
    end
    step();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    repeat (3) @(negedge clock);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    // Reset while a write sits in P behind a stream of hits.
    step();
    drive(1'b1, 7'd50, 44'h5A5_A5A5_A5A5, 4'hF, 1'b0, '0);
    step();
    drive(1'b0, '0, '0, '0, 1'b1, 7'd50);
    step();
    @(negedge clock);
    check("midrst_pre_valid", 64'(R0_valid), 64'd1);
    check("midrst_pre_csb0", 64'(mem_csb0), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_r0_valid", 64'(R0_valid), 64'd0);
    check("midrst_w0_ready", 64'(W0_ready), 64'd0);
    check("midrst_init_done", 64'(init_done), 64'd0);
    check("midrst_dbg_state", 64'(dbg_state), 64'd0);
    reset_and_init();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("no_lost_write_commit", 64'(mem_csb0), 64'd1);
    end
    step();
    drive(1'b0, '0, '0, '0, 1'b1, 7'd50);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    @(negedge clock);
    check("midrst_read50_valid", 64'(R0_valid), 64'd1);
    check("midrst_read50_data", 64'(R0_data), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
